// File: rtl/sm_extout_logger_if.sv
// Bus bundle between the extOutput change logger and its environment:
// sampled inputs, controls and the FWFT drain port.
interface sm_extout_logger_if #(
   parameter int DATA_W  = 32,
   parameter int STAMP_W = 16,
   parameter int ADDR_W  = 3
);
   logic               en;
   logic               clr;
   logic [DATA_W-1:0]  extOutput;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic [STAMP_W-1:0] out_stamp;
   logic [ADDR_W:0]    level;
   logic               overflow;
   logic [7:0]         overflow_cnt;

   // master: the logger itself; slave: whoever feeds and drains it
   modport master (
      input  en, clr, extOutput, out_ready,
      output out_valid, out_data, out_stamp, level, overflow, overflow_cnt
   );
   modport slave (
      output en, clr, extOutput, out_ready,
      input  out_valid, out_data, out_stamp, level, overflow, overflow_cnt
   );
endinterface

// File: rtl/sm_extout_logger.sv
// Logs every change of extOutput as {timestamp, value} into a FWFT FIFO,
// with a sticky overflow flag and saturating drop counter.
module sm_extout_logger #(
   parameter int DATA_W  = 32,
   parameter int STAMP_W = 16,
   parameter int ADDR_W  = 3
) (
   input logic                clk,
   input logic                rst_n,
   sm_extout_logger_if.master bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [STAMP_W-1:0] stamp_q, stamp_d;
   logic [DATA_W-1:0]  prev_q, prev_d;
   logic [ADDR_W:0]    wr_q, wr_d, rd_q, rd_d;
   logic               ovf_q, ovf_d;
   logic [7:0]         ovf_cnt_q, ovf_cnt_d;

   logic [DATA_W-1:0]  data_mem  [DEPTH];
   logic [STAMP_W-1:0] stamp_mem [DEPTH];

   logic [ADDR_W:0] level;
   logic            empty, full, push_req, pop, push, mem_we;

   always_comb begin
      level     = wr_q - rd_q;
      empty     = (level == '0);
      full      = (level == {1'b1, {ADDR_W{1'b0}}});
      push_req  = bus.en && (bus.extOutput != prev_q);
      pop       = !empty && bus.out_ready;
      // a pop frees a slot in the same edge, so full+pop still accepts the push
      push      = push_req && (!full || pop);
      mem_we    = push && !bus.clr;

      stamp_d   = stamp_q;
      prev_d    = prev_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;

      if (bus.clr) begin
         stamp_d   = '0;
         prev_d    = bus.extOutput;
         wr_d      = '0;
         rd_d      = '0;
         ovf_d     = 1'b0;
         ovf_cnt_d = '0;
      end else begin
         if (bus.en) begin
            prev_d  = bus.extOutput;
            stamp_d = stamp_q + 1'b1;
         end
         if (pop)  rd_d = rd_q + 1'b1;
         if (push) wr_d = wr_q + 1'b1;
         if (push_req && full && !pop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stamp_q   <= '0;
         prev_q    <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
      end else begin
         stamp_q   <= stamp_d;
         prev_q    <= prev_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   // storage needs no reset: empty pointers mask its contents
   always_ff @(posedge clk) begin
      if (mem_we) begin
         data_mem[wr_q[ADDR_W-1:0]]  <= bus.extOutput;
         stamp_mem[wr_q[ADDR_W-1:0]] <= stamp_q;
      end
   end

   assign bus.out_valid    = !empty;
   assign bus.out_data     = empty ? '0 : data_mem[rd_q[ADDR_W-1:0]];
   assign bus.out_stamp    = empty ? '0 : stamp_mem[rd_q[ADDR_W-1:0]];
   assign bus.level        = level;
   assign bus.overflow     = ovf_q;
   assign bus.overflow_cnt = ovf_cnt_q;
endmodule

// File: tb/tb_sm_extout_logger.sv
// Checks sm_extout_logger (16-bit and 4-bit stamp instances, shared stimulus)
// against a queue-based reference model, a vector table and directed corners.
module tb_sm_extout_logger;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en, clr, rdy;
   logic [31:0] ext;

   always #5 clk = ~clk;

   sm_extout_logger_if #(.DATA_W(32), .STAMP_W(16), .ADDR_W(3)) bus16 ();
   sm_extout_logger_if #(.DATA_W(32), .STAMP_W(4),  .ADDR_W(3)) bus4 ();

   assign bus16.en = en;  assign bus16.clr = clr;
   assign bus16.out_ready = rdy;  assign bus16.extOutput = ext;
   assign bus4.en = en;   assign bus4.clr = clr;
   assign bus4.out_ready = rdy;   assign bus4.extOutput = ext;

   sm_extout_logger #(.DATA_W(32), .STAMP_W(16), .ADDR_W(3)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16));
   sm_extout_logger #(.DATA_W(32), .STAMP_W(4), .ADDR_W(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4));

   int unsigned n_chk = 0, n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: unbounded stamp, queue of logged entries
   typedef struct { int unsigned st; logic [31:0] d; } ent_t;
   ent_t        mq[$];
   int unsigned m_stamp, m_cnt;
   logic [31:0] m_prev;
   bit          m_ovf;

   task automatic model_reset();
      mq.delete(); m_stamp = 0; m_cnt = 0; m_prev = '0; m_ovf = 0;
   endtask

   task automatic model_step();
      bit do_pop, do_push;
      ent_t e;
      if (clr) begin
         mq.delete(); m_stamp = 0; m_ovf = 0; m_cnt = 0; m_prev = ext;
         return;
      end
      do_pop  = (mq.size() != 0) && rdy;
      do_push = en && (ext != m_prev);
      e.st = m_stamp; e.d = ext;
      if (en) begin m_prev = ext; m_stamp++; end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (mq.size() < 8) mq.push_back(e);
         else begin m_ovf = 1; if (m_cnt < 255) m_cnt++; end
      end
   endtask

   task automatic compare_model();
      bit ne;
      ne = (mq.size() != 0);
      check("valid",   bus16.out_valid, ne);
      check("level",   bus16.level, mq.size());
      check("data",    bus16.out_data, ne ? mq[0].d : 32'h0);
      check("stamp16", bus16.out_stamp, ne ? (mq[0].st & 32'hFFFF) : 0);
      check("ovf",     bus16.overflow, m_ovf);
      check("ovf_cnt", bus16.overflow_cnt, m_cnt);
      check("valid4",  bus4.out_valid, ne);
      check("level4",  bus4.level, mq.size());
      check("stamp4",  bus4.out_stamp, ne ? (mq[0].st & 32'hF) : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      check("rst_valid", bus16.out_valid, 0);
      check("rst_data",  bus16.out_data, 0);
      check("rst_stamp", bus16.out_stamp, 0);
      check("rst_level", bus16.level, 0);
      compare_model();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit en, clr, rdy; logic [31:0] ext;
      bit e_valid; int unsigned e_level; logic [31:0] e_data; bit e_ovf; int unsigned e_cnt;
   } vec_t;
   vec_t vt[19];

   function automatic vec_t mk(input bit e, input bit r, input logic [31:0] x, input bit v,
                               input int unsigned l, input logic [31:0] d, input bit o,
                               input int unsigned c);
      vec_t t;
      t.en = e; t.clr = 1'b0; t.rdy = r; t.ext = x;
      t.e_valid = v; t.e_level = l; t.e_data = d; t.e_ovf = o; t.e_cnt = c;
      return t;
   endfunction

   initial begin
      // 10 pushes into an 8-deep FIFO, then push+pop while full, then drain
      for (int unsigned i = 0; i < 10; i++)
         vt[i] = mk(1'b1, 1'b0, 32'h100 + i, 1'b1, (i < 8) ? i + 1 : 8, 32'h100,
                    i >= 8, (i >= 8) ? i - 7 : 0);
      vt[10] = mk(1'b1, 1'b1, 32'h200, 1'b1, 8, 32'h101, 1'b1, 2);
      for (int unsigned j = 0; j < 8; j++)
         vt[11 + j] = mk(1'b0, 1'b1, 32'h200, j < 7, 7 - j,
                         (j < 6) ? 32'h102 + j : ((j == 6) ? 32'h200 : 32'h0), 1'b1, 2);

      en = 0; clr = 0; rdy = 0; ext = '0;
      model_reset();
      #12;
      compare_model();
      @(negedge clk); rst_n = 1'b1;

      // idle at zero: nothing logged
      en = 1;
      repeat (20) tick();
      check("idle_valid", bus16.out_valid, 0);
      check("idle_level", bus16.level, 0);

      // first change at stamp 5
      async_reset();
      repeat (5) tick();
      ext = 32'h12; tick();
      check("s2_valid", bus16.out_valid, 1);
      check("s2_data",  bus16.out_data, 32'h12);
      check("s2_stamp", bus16.out_stamp, 5);
      rdy = 1; tick(); rdy = 0;
      check("s2_popped", bus16.out_valid, 0);

      // overflow, full push+pop, drain order
      foreach (vt[k]) begin
         en = vt[k].en; clr = vt[k].clr; rdy = vt[k].rdy; ext = vt[k].ext;
         tick();
         check($sformatf("vec%0d_valid", k), bus16.out_valid, vt[k].e_valid);
         check($sformatf("vec%0d_level", k), bus16.level, vt[k].e_level);
         check($sformatf("vec%0d_data", k), bus16.out_data, vt[k].e_data);
         check($sformatf("vec%0d_ovf", k), bus16.overflow, vt[k].e_ovf);
         check($sformatf("vec%0d_cnt", k), bus16.overflow_cnt, vt[k].e_cnt);
      end
      rdy = 0;

      // stamp wrap on the 4-bit instance, freeze while en=0
      async_reset();
      en = 1; ext = '0;
      repeat (16) tick();
      ext = 32'h55; tick();
      check("wrap_stamp4",  bus4.out_stamp, 0);
      check("wrap_stamp16", bus16.out_stamp, 16);
      en = 0;
      for (int unsigned i = 0; i < 5; i++) begin ext = 32'h1000 + i; tick(); end
      check("en0_level", bus16.level, 1);
      en = 1; ext = 32'h77; rdy = 1; tick(); rdy = 0;
      check("frz_data",    bus16.out_data, 32'h77);
      check("frz_stamp16", bus16.out_stamp, 17);
      check("frz_stamp4",  bus4.out_stamp, 1);
      check("frz_level",   bus16.level, 1);

      // clr with level 3 and a changing input
      for (int unsigned i = 0; i < 10; i++) begin ext = 32'h300 + i; tick(); end
      en = 0; rdy = 1;
      repeat (5) tick();
      rdy = 0;
      check("pre_clr_level", bus16.level, 3);
      en = 1; clr = 1; ext = 32'hABC; rdy = 1; tick(); clr = 0; rdy = 0;
      check("clr_level", bus16.level, 0);
      check("clr_ovf",   bus16.overflow, 0);
      check("clr_cnt",   bus16.overflow_cnt, 0);
      ext = 32'hDEF; tick();
      check("post_clr_level", bus16.level, 1);
      check("post_clr_stamp", bus16.out_stamp, 0);
      ext = 32'hE01; tick();
      ext = 32'hE02; tick();
      rdy = 1; tick();
      #2 async_reset();
      rdy = 0;

      // drop counter saturation
      en = 1;
      for (int unsigned i = 0; i < 300; i++) begin ext = i + 1; tick(); end
      check("sat_cnt", bus16.overflow_cnt, 8'hFF);
      check("sat_ovf", bus16.overflow, 1);

      // randomized traffic
      for (int unsigned i = 0; i < 2000; i++) begin
         en  = ($urandom % 4) != 0;
         clr = ($urandom % 64) == 0;
         rdy = ($urandom % 2) != 0;
         ext = 32'($urandom_range(0, 3));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
